// File: rtl/cr16_alu_stepper.sv
// cr16_alu_stepper -- drives a cr16_alu from a chunk-wide switch bank and a
// single push button. Operands are entered MSB chunk first (A, then B), then
// the opcode; one EXEC cycle latches the ALU result/status, and the block
// holds until the next press starts a new operation.
//
// Ports
//   I_CLK       system clock, rising edge
//   I_RST       asynchronous reset, active low
//   I_INPUT     chunk / opcode value from the switches (asynchronous)
//   I_STEP      push button, active low (asynchronous)
//   I_DISP_SEL  0 result, 1 A, 2 B, 3 zero-extended opcode
//   O_DISPLAY   registered view of the selected source
//   O_STATUS    ALU status of the last executed operation {N,Z,F,L,C}
//   O_PHASE     0 LOAD_A, 1 LOAD_B, 2 LOAD_OP, 3 EXEC/HOLD
//   O_CHUNK     index of the next chunk to load
//   O_DONE      high for the single EXEC cycle
//
// Also contains cr16_alu, the combinational ALU the stepper drives.

// cr16_alu -- combinational ALU.
//   I_A, I_B   operands        I_OP      opcode (0 ADD, 1 SUB, 2 AND, 3 OR,
//   I_ENABLE   gates outputs               4 XOR, 5 NOT A, 6 MOV B, else 0)
//   O_C        result          O_STATUS  {N, Z, F(overflow), L(A<B unsigned),
//                                          C(carry out / borrow)}
module cr16_alu #(
  parameter int P_WIDTH        = 16,
  parameter int P_OPCODE_WIDTH = 5
) (
  input  logic [P_WIDTH-1:0]        I_A,
  input  logic [P_WIDTH-1:0]        I_B,
  input  logic [P_OPCODE_WIDTH-1:0] I_OP,
  input  logic                      I_ENABLE,
  output logic [P_WIDTH-1:0]        O_C,
  output logic [4:0]                O_STATUS
);
  localparam logic [P_OPCODE_WIDTH-1:0] OP_ADD  = P_OPCODE_WIDTH'(0);
  localparam logic [P_OPCODE_WIDTH-1:0] OP_SUB  = P_OPCODE_WIDTH'(1);
  localparam logic [P_OPCODE_WIDTH-1:0] OP_AND  = P_OPCODE_WIDTH'(2);
  localparam logic [P_OPCODE_WIDTH-1:0] OP_OR   = P_OPCODE_WIDTH'(3);
  localparam logic [P_OPCODE_WIDTH-1:0] OP_XOR  = P_OPCODE_WIDTH'(4);
  localparam logic [P_OPCODE_WIDTH-1:0] OP_NOT  = P_OPCODE_WIDTH'(5);
  localparam logic [P_OPCODE_WIDTH-1:0] OP_MOVB = P_OPCODE_WIDTH'(6);
  localparam int MSB = P_WIDTH - 1;

  logic [P_WIDTH:0]   sum;
  logic [P_WIDTH-1:0] c;
  logic               carry, ovf;

  always_comb begin
    sum   = '0;
    c     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (I_OP)
      OP_ADD: begin
        sum   = {1'b0, I_A} + {1'b0, I_B};
        c     = sum[MSB:0];
        carry = sum[P_WIDTH];
        ovf   = (I_A[MSB] == I_B[MSB]) && (c[MSB] != I_A[MSB]);
      end
      OP_SUB: begin
        // extra bit of the subtraction is the borrow
        sum   = {1'b0, I_A} - {1'b0, I_B};
        c     = sum[MSB:0];
        carry = sum[P_WIDTH];
        ovf   = (I_A[MSB] != I_B[MSB]) && (c[MSB] != I_A[MSB]);
      end
      OP_AND:  c = I_A & I_B;
      OP_OR:   c = I_A | I_B;
      OP_XOR:  c = I_A ^ I_B;
      OP_NOT:  c = ~I_A;
      OP_MOVB: c = I_B;
      default: c = '0;
    endcase
  end

  assign O_C      = I_ENABLE ? c : '0;
  assign O_STATUS = I_ENABLE ? {c[MSB], (c == '0), ovf, (I_A < I_B), carry} : 5'd0;
endmodule

module cr16_alu_stepper #(
  parameter  int P_WIDTH        = 16,
  parameter  int P_INPUT_WIDTH  = 8,
  parameter  int P_OPCODE_WIDTH = 5,
  localparam int N              = P_WIDTH / P_INPUT_WIDTH,
  localparam int CW             = (N > 1) ? $clog2(N) : 1
) (
  input  logic                     I_CLK,
  input  logic                     I_RST,
  input  logic [P_INPUT_WIDTH-1:0] I_INPUT,
  input  logic                     I_STEP,
  input  logic [1:0]               I_DISP_SEL,
  output logic [P_WIDTH-1:0]       O_DISPLAY,
  output logic [4:0]               O_STATUS,
  output logic [1:0]               O_PHASE,
  output logic [CW-1:0]            O_CHUNK,
  output logic                     O_DONE
);
  typedef enum logic [2:0] {S_LOAD_A, S_LOAD_B, S_LOAD_OP, S_EXEC, S_HOLD} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             chunk_q, chunk_d;
  logic [P_WIDTH-1:0]        a_q, b_q, res_q, disp_q, disp_d;
  logic [P_OPCODE_WIDTH-1:0] op_q;
  logic [4:0]                status_q;
  logic [P_WIDTH-1:0]        alu_c;
  logic [4:0]                alu_status;
  logic                      ld_a, ld_b, ld_op, exec, chunk_last;
  logic [1:0]                phase;

  // Button: two-flop synchroniser plus an edge register, all idling high.
  // smp_vld marks that step_s1 holds a real sample rather than its reset
  // value; armed is set only once a released level has actually been seen,
  // so a button held through reset release cannot fake a falling edge.
  logic step_s1, step_s2, step_s3, smp_vld, armed, step_pulse;

  always_ff @(posedge I_CLK or negedge I_RST) begin
    if (!I_RST) begin
      step_s1 <= 1'b1;
      step_s2 <= 1'b1;
      step_s3 <= 1'b1;
      smp_vld <= 1'b0;
      armed   <= 1'b0;
    end else begin
      step_s1 <= I_STEP;
      step_s2 <= step_s1;
      step_s3 <= step_s2;
      smp_vld <= 1'b1;
      armed   <= armed | (smp_vld & step_s1);
    end
  end

  assign step_pulse = step_s3 & ~step_s2 & armed;
  assign chunk_last = (chunk_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_op   = 1'b0;
    exec    = 1'b0;
    phase   = 2'd0;
    case (state_q)
      S_LOAD_A, S_LOAD_B: begin
        phase = (state_q == S_LOAD_A) ? 2'd0 : 2'd1;
        if (step_pulse) begin
          ld_a = (state_q == S_LOAD_A);
          ld_b = (state_q == S_LOAD_B);
          if (chunk_last) begin
            chunk_d = '0;
            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_LOAD_OP;
          end else begin
            chunk_d = chunk_q + CW'(1);
          end
        end
      end
      S_LOAD_OP: begin
        phase = 2'd2;
        if (step_pulse) begin
          ld_op   = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // any pulse landing here is dropped
        phase   = 2'd3;
        exec    = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        phase = 2'd3;
        if (step_pulse) begin
          state_d = S_LOAD_A;
          chunk_d = '0;
        end
      end
      default: begin
        state_d = S_LOAD_A;
        chunk_d = '0;
      end
    endcase
  end

  always_comb begin
    disp_d = res_q;
    case (I_DISP_SEL)
      2'd0:    disp_d = res_q;
      2'd1:    disp_d = a_q;
      2'd2:    disp_d = b_q;
      default: disp_d = P_WIDTH'(op_q);
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST) begin
    if (!I_RST) begin
      state_q  <= S_LOAD_A;
      chunk_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      status_q <= '0;
      disp_q   <= '0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      // chunk_cnt 0 addresses the top chunk: operands are keyed in MSB first
      for (int i = 0; i < N; i++) begin
        if (ld_a && chunk_q == CW'(N - 1 - i))
          a_q[i*P_INPUT_WIDTH +: P_INPUT_WIDTH] <= I_INPUT;
        if (ld_b && chunk_q == CW'(N - 1 - i))
          b_q[i*P_INPUT_WIDTH +: P_INPUT_WIDTH] <= I_INPUT;
      end
      if (ld_op) op_q <= I_INPUT[P_OPCODE_WIDTH-1:0];
      if (exec) begin
        res_q    <= alu_c;
        status_q <= alu_status;
      end
      disp_q <= disp_d;
    end
  end

  cr16_alu #(
    .P_WIDTH        (P_WIDTH),
    .P_OPCODE_WIDTH (P_OPCODE_WIDTH)
  ) u_alu (
    .I_A      (a_q),
    .I_B      (b_q),
    .I_OP     (op_q),
    .I_ENABLE (1'b1),
    .O_C      (alu_c),
    .O_STATUS (alu_status)
  );

  assign O_DISPLAY = disp_q;
  assign O_STATUS  = status_q;
  assign O_PHASE   = phase;
  assign O_CHUNK   = chunk_q;
  assign O_DONE    = (state_q == S_EXEC);
endmodule

// File: tb/tb_cr16_alu_stepper.sv
// Bench for cr16_alu_stepper: three instances (16/8, 32/8, 8/8) share the
// same switches, button, select and reset. A behavioural model tracks each
// one as a position in the step sequence and is compared on every cycle;
// directed scenarios add hand-computed expectations.
module tb_cr16_alu_stepper;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] inp = 8'd0;
  logic       step = 1'b1;
  logic [1:0] sel = 2'd0;

  logic [15:0] disp0;  logic [31:0] disp1;  logic [7:0] disp2;
  logic [4:0]  st0, st1, st2;
  logic [1:0]  ph0, ph1, ph2;
  logic        ch0;    logic [1:0]  ch1;    logic       ch2;
  logic        dn0, dn1, dn2;

  int vectors = 0;
  int miscompares = 0;
  int dn_cnt0 = 0;

  cr16_alu_stepper #(.P_WIDTH(16), .P_INPUT_WIDTH(8), .P_OPCODE_WIDTH(5)) u_d0 (
    .I_CLK(clk), .I_RST(rst_n), .I_INPUT(inp), .I_STEP(step), .I_DISP_SEL(sel),
    .O_DISPLAY(disp0), .O_STATUS(st0), .O_PHASE(ph0), .O_CHUNK(ch0), .O_DONE(dn0));
  cr16_alu_stepper #(.P_WIDTH(32), .P_INPUT_WIDTH(8), .P_OPCODE_WIDTH(5)) u_d1 (
    .I_CLK(clk), .I_RST(rst_n), .I_INPUT(inp), .I_STEP(step), .I_DISP_SEL(sel),
    .O_DISPLAY(disp1), .O_STATUS(st1), .O_PHASE(ph1), .O_CHUNK(ch1), .O_DONE(dn1));
  cr16_alu_stepper #(.P_WIDTH(8), .P_INPUT_WIDTH(8), .P_OPCODE_WIDTH(5)) u_d2 (
    .I_CLK(clk), .I_RST(rst_n), .I_INPUT(inp), .I_STEP(step), .I_DISP_SEL(sel),
    .O_DISPLAY(disp2), .O_STATUS(st2), .O_PHASE(ph2), .O_CHUNK(ch2), .O_DONE(dn2));

  initial forever #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // pos counts completed steps: 0..2N-1 operand chunks, 2N opcode,
  // 2N+1 the execute cycle, 2N+2 holding the result.
  int          mw[3] = '{16, 32, 8};
  int          mn[3] = '{2, 4, 1};
  int          pos[3] = '{0, 0, 0};
  logic [31:0] ma[3] = '{0, 0, 0};
  logic [31:0] mb[3] = '{0, 0, 0};
  logic [31:0] mres[3] = '{0, 0, 0};
  logic [31:0] mdisp[3] = '{0, 0, 0};
  logic [4:0]  mop[3] = '{0, 0, 0};
  logic [4:0]  mst[3] = '{0, 0, 0};
  logic        hist[$];

  task automatic alu_model(input int w, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, output logic [31:0] r, output logic [4:0] st);
    longint la, lb, m, half, sa, sb, s;
    logic c, f, n;
    la = longint'(a); lb = longint'(b);
    m = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sa = (la >= half) ? la - 2 * half : la;
    sb = (lb >= half) ? lb - 2 * half : lb;
    c = 1'b0; f = 1'b0; s = 0;
    case (op)
      5'd0: begin s = la + lb; c = (s > m); f = (sa + sb >= half) || (sa + sb < -half); end
      5'd1: begin s = la - lb; c = (la < lb); f = (sa - sb >= half) || (sa - sb < -half); end
      5'd2: s = la & lb;
      5'd3: s = la | lb;
      5'd4: s = la ^ lb;
      5'd5: s = ~la;
      5'd6: s = lb;
      default: s = 0;
    endcase
    s = s & m;
    r = 32'(s);
    n = ((s >> (w - 1)) & 1) != 0;
    st = {n, (s == 0), f, (la < lb), c};
  endtask

  task automatic model_edge(input int k, input logic pulse);
    logic [31:0] nd, r, msk;
    logic [4:0]  st;
    int n, sh;
    n = mn[k];
    case (sel)
      2'd0: nd = mres[k];
      2'd1: nd = ma[k];
      2'd2: nd = mb[k];
      default: nd = {27'd0, mop[k]};
    endcase
    if (pos[k] == 2 * n + 1) begin
      alu_model(mw[k], mop[k], ma[k], mb[k], r, st);
      mres[k] = r; mst[k] = st;
      pos[k] = 2 * n + 2;
    end else if (pulse) begin
      if (pos[k] < 2 * n) begin
        sh = (n - 1 - (pos[k] % n)) * 8;
        msk = 32'hFF << sh;
        if (pos[k] < n) ma[k] = (ma[k] & ~msk) | ({24'd0, inp} << sh);
        else            mb[k] = (mb[k] & ~msk) | ({24'd0, inp} << sh);
        pos[k]++;
      end else if (pos[k] == 2 * n) begin
        mop[k] = inp[4:0];
        pos[k]++;
      end else begin
        pos[k] = 0;
      end
    end
    mdisp[k] = nd;
  endtask

  initial begin
    logic pulse;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        hist.delete();
        for (int k = 0; k < 3; k++) begin
          pos[k] = 0; ma[k] = 0; mb[k] = 0; mres[k] = 0;
          mdisp[k] = 0; mop[k] = 0; mst[k] = 0;
        end
      end else begin
        // a press acts two edges after its first low sample, and only if
        // the sample before that was a genuine released level
        pulse = (hist.size() >= 3) && hist[hist.size()-3] && !hist[hist.size()-2];
        hist.push_back(step);
        if (hist.size() > 3) void'(hist.pop_front());
        for (int k = 0; k < 3; k++) model_edge(k, pulse);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL d%0d %s: got %h expected %h at %0t", k, nm, got, exp, $time);
    end
  endtask

  initial begin
    logic [31:0] g_disp, g_st, g_ph, g_ch, g_dn, e_ph, e_ch, wm;
    int n;
    forever begin
      @(posedge clk);
      #2;
      if (dn0) dn_cnt0++;
      for (int k = 0; k < 3; k++) begin
        case (k)
          0: begin g_disp = {16'd0, disp0}; g_st = {27'd0, st0}; g_ph = {30'd0, ph0};
                   g_ch = {31'd0, ch0}; g_dn = {31'd0, dn0}; end
          1: begin g_disp = disp1; g_st = {27'd0, st1}; g_ph = {30'd0, ph1};
                   g_ch = {30'd0, ch1}; g_dn = {31'd0, dn1}; end
          default: begin g_disp = {24'd0, disp2}; g_st = {27'd0, st2}; g_ph = {30'd0, ph2};
                   g_ch = {31'd0, ch2}; g_dn = {31'd0, dn2}; end
        endcase
        n = mn[k];
        wm = (mw[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << mw[k]) - 1);
        e_ph = (pos[k] < n) ? 0 : (pos[k] < 2 * n) ? 1 : (pos[k] == 2 * n) ? 2 : 3;
        e_ch = (pos[k] < 2 * n) ? 32'(pos[k] % n) : 0;
        chk("phase", k, g_ph, e_ph);
        chk("chunk", k, g_ch, e_ch);
        chk("done", k, g_dn, {31'd0, pos[k] == 2 * n + 1});
        chk("display", k, g_disp, mdisp[k] & wm);
        chk("status", k, g_st, {27'd0, mst[k]});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] v, input int hold);
    inp = v;
    step = 1'b0;
    tick(hold);
    step = 1'b1;
    tick(3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    int base;
    tick(3);
    chk("rst_phase", 0, {30'd0, ph0}, 0);
    chk("rst_disp", 0, {16'd0, disp0}, 0);
    chk("rst_done", 0, {31'd0, dn0}, 0);
    rst_n = 1'b1;
    tick(2);

    // full ADD sequence
    base = dn_cnt0;
    press(8'h12, 1); press(8'h34, 2); press(8'h56, 1); press(8'h78, 3); press(8'h00, 1);
    sel = 2'd1; tick(2); chk("seq_A", 0, {16'd0, disp0}, 32'h1234);
    sel = 2'd2; tick(2); chk("seq_B", 0, {16'd0, disp0}, 32'h5678);
    sel = 2'd0; tick(2); chk("seq_res", 0, {16'd0, disp0}, 32'h68AC);
    chk("seq_done_cnt", 0, 32'(dn_cnt0 - base), 1);
    chk("seq_phase", 0, {30'd0, ph0}, 3);
    chk("seq_status", 0, {27'd0, st0}, 32'h02);

    // second run from HOLD: 0xFFFF + 0x0001 wraps with carry
    base = dn_cnt0;
    press(8'h5A, 1);
    chk("wrap_phase", 0, {30'd0, ph0}, 0);
    press(8'hFF, 1); press(8'hFF, 1);
    chk("wrap_keep_res", 0, {16'd0, disp0}, 32'h68AC);
    press(8'h00, 1); press(8'h01, 1);
    chk("wrap_keep_st", 0, {27'd0, st0}, 32'h02);
    press(8'h00, 1);
    tick(2);
    chk("wrap_res", 0, {16'd0, disp0}, 32'h0000);
    chk("wrap_status", 0, {27'd0, st0}, 32'h09);
    chk("wrap_done_cnt", 0, 32'(dn_cnt0 - base), 1);

    // long hold on the first chunk, with partial-operand display
    do_reset();
    sel = 2'd1;
    inp = 8'hAB;
    step = 1'b0;
    tick(1); chk("hold_k", 0, {31'd0, ch0}, 0);
    tick(1); chk("hold_k1", 0, {31'd0, ch0}, 0);
    tick(1); chk("hold_k2", 0, {31'd0, ch0}, 1);
    tick(47);
    step = 1'b1;
    tick(3);
    chk("hold_chunk", 0, {31'd0, ch0}, 1);
    chk("hold_phase", 0, {30'd0, ph0}, 0);
    chk("partial_disp", 0, {16'd0, disp0}, 32'hAB00);
    chk("partial_disp32", 1, disp1, 32'hAB00_0000);

    // reset part way through loading
    press(8'h11, 1); press(8'h22, 1);
    chk("mid_phase", 0, {30'd0, ph0}, 1);
    base = dn_cnt0;
    rst_n = 1'b0;
    tick(1);
    chk("abort_phase", 0, {30'd0, ph0}, 0);
    chk("abort_chunk", 0, {31'd0, ch0}, 0);
    chk("abort_disp", 0, {16'd0, disp0}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("abort_no_done", 0, 32'(dn_cnt0 - base), 0);

    // button held down through reset release
    rst_n = 1'b0;
    step = 1'b0;
    inp = 8'hC3;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    step = 1'b1;
    tick(3);
    chk("held_rst_chunk", 0, {31'd0, ch0}, 0);
    chk("held_rst_disp", 0, {16'd0, disp0}, 0);

    // width sweep: 32-bit takes four steps per operand, 8-bit takes one
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("sweep_chunk", 1, {30'd0, ch1}, 32'(i));
      press(8'($urandom), 1);
      if (i == 0) chk("sweep_n1_ph", 2, {30'd0, ph2}, 1);
      if (i == 1) chk("sweep_n1_ph", 2, {30'd0, ph2}, 2);
    end
    chk("sweep_phase", 1, {30'd0, ph1}, 1);
    chk("sweep_chunk_wrap", 1, {30'd0, ch1}, 0);

    // random traffic
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_reset();
      end else if (r < 15) begin
        sel = 2'($urandom_range(0, 3));
        tick($urandom_range(1, 3));
      end else begin
        press($urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'($urandom),
              $urandom_range(1, 6));
      end
    end

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cr16_alu_stepper.md
CR16_ALU_STEPPER -- requirements
Module: cr16_alu_stepper

Interface
REQ-001 Parameter P_WIDTH, default 16, is the operand and result width in bits.
REQ-002 Parameter P_INPUT_WIDTH, default 8, is the width of one operand chunk.
- P_WIDTH SHALL be an integer multiple of P_INPUT_WIDTH.
- N = P_WIDTH/P_INPUT_WIDTH.
REQ-003 Parameter P_OPCODE_WIDTH, default 5, is the opcode width.
- P_OPCODE_WIDTH SHALL be <= P_INPUT_WIDTH.
REQ-004 I_CLK  in  1  system clock; all state SHALL change on the rising edge only.
REQ-005 I_RST  in  1  asynchronous, active-low reset.
REQ-006 I_INPUT  in  P_INPUT_WIDTH  chunk value from the switches; asynchronous, sampled on step.
REQ-007 I_STEP  in  1  asynchronous push button, active-low; a press is a 1->0 transition.
REQ-008 I_DISP_SEL  in  2  display source: 0 = result, 1 = A, 2 = B, 3 = zero-extended opcode.
REQ-009 O_DISPLAY  out  P_WIDTH  registered value selected by I_DISP_SEL.
REQ-010 O_STATUS  out  5  latched cr16_alu status of the last executed operation.
REQ-011 O_PHASE  out  2  current phase: 0 = LOAD_A, 1 = LOAD_B, 2 = LOAD_OP, 3 = EXEC/HOLD.
REQ-012 O_CHUNK  out  clog2(N) (minimum 1)  index of the next chunk to load.
REQ-013 O_DONE  out  1  one-cycle pulse when a result is latched.

Function
REQ-014 The block SHALL instantiate cr16_alu with P_WIDTH, I_ENABLE tied 1, and inputs from registers A, B and OP.
REQ-015 Step synchronisation:
- I_STEP SHALL pass through a two-flop synchroniser, then a third edge register.
- step_pulse = edge register high AND second flop low.
- A low first sampled at edge k SHALL be acted on at edge k+2.
REQ-016 Each press SHALL produce exactly one step_pulse, however long the button is held.
REQ-017 States: LOAD_A, LOAD_B, LOAD_OP, EXEC, HOLD.
REQ-018 In LOAD_A or LOAD_B, each step_pulse SHALL write I_INPUT into chunk (N-1-chunk_cnt) of the target operand, loading MSB chunk first.
- Other chunks SHALL be unchanged.
- chunk_cnt SHALL then increment.
REQ-019 When chunk_cnt = N-1 on a step_pulse:
- chunk_cnt SHALL wrap to 0.
- The state SHALL advance LOAD_A->LOAD_B or LOAD_B->LOAD_OP.
REQ-020 In LOAD_OP, a step_pulse SHALL:
- load OP <= I_INPUT[P_OPCODE_WIDTH-1:0];
- go to EXEC.
REQ-021 EXEC SHALL last exactly one cycle, then go to HOLD. In that cycle the block SHALL:
- latch the cr16_alu O_C into the result register;
- latch the cr16_alu O_STATUS into O_STATUS;
- assert O_DONE for that one cycle.
REQ-022 In HOLD, a step_pulse SHALL go to LOAD_A with chunk_cnt = 0.
- A, B, OP, result and O_STATUS SHALL be retained until overwritten.
REQ-023 A step_pulse arriving in EXEC SHALL be ignored, with no state or register change.
REQ-024 O_DISPLAY SHALL be updated every cycle from I_DISP_SEL, giving one cycle of latency from a select or source change.
- While an operand is being loaded, it SHALL show the partially assembled operand.
REQ-025 O_PHASE SHALL read 3 in both EXEC and HOLD.
REQ-026 The result SHALL be exactly the cr16_alu output at P_WIDTH bits, with no extension or truncation.
REQ-027 With N = 1, each operand SHALL take one step and O_CHUNK SHALL stay 0.

Reset
REQ-028 While I_RST = 0, the following SHALL hold:
- state = LOAD_A and chunk_cnt = 0;
- A, B, OP, result, O_STATUS, O_DISPLAY = 0;
- O_DONE = 0;
- all three step registers = 1 (released).
REQ-029 Reset asserted mid-load or in EXEC SHALL abort the operation with no O_DONE.
- A press held through reset release SHALL NOT produce a step_pulse.

Verification (P_WIDTH=16, P_INPUT_WIDTH=8)
REQ-030 The bench SHALL cover the following directed scenarios:
- Full sequence: reset; steps with I_INPUT 0x12, 0x34, 0x56, 0x78, then the ADD opcode. Then I_DISP_SEL=1 -> 0x1234; =2 -> 0x5678; =0 -> 0x68AC with O_DONE pulsed once; O_PHASE=3.
- Hold press: keep I_STEP low for 50 cycles at the first chunk. Result: one load only, O_CHUNK=1, action exactly 2 edges after the first low sample.
- Reset mid-load: reset after 3 chunk steps. Result: O_PHASE=0, O_CHUNK=0, O_DISPLAY=0, O_DONE never asserted.
- Wrap: run a second full sequence after HOLD with 0xFF, 0xFF, 0x00, 0x01, ADD. Result = 0x0000 with the carry flag set in O_STATUS; previous values shown until overwritten.
- Partial display: I_DISP_SEL=1 after the first A chunk 0xAB. O_DISPLAY = 0xAB00.
- Parameter sweep: P_WIDTH=32, P_INPUT_WIDTH=8 needs 4 steps per operand with O_CHUNK 0..3. P_WIDTH=P_INPUT_WIDTH=8 needs 1 step per operand.
